// File: rtl/serv_mdu_pkg.sv
// Shared encodings for the serial multiply/divide unit.
// Holds funct3 codes, FSM states and the default step count.
package serv_mdu_pkg;

  localparam int ITER_DEF = 32;

  typedef logic [2:0] funct3_t;

  localparam funct3_t OP_MUL    = 3'd0;
  localparam funct3_t OP_MULH   = 3'd1;
  localparam funct3_t OP_MULHSU = 3'd2;
  localparam funct3_t OP_MULHU  = 3'd3;
  localparam funct3_t OP_DIV    = 3'd4;
  localparam funct3_t OP_DIVU   = 3'd5;
  localparam funct3_t OP_REM    = 3'd6;
  localparam funct3_t OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE,
    S_HOLD
  } state_e;

  function automatic logic op_is_div(input funct3_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input funct3_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/serv_mdu_resp_if.sv
// Request/response bundle between core state unit and MDU.
// The core drives the request side, the MDU the result side.
interface serv_mdu_resp_if;
  import serv_mdu_pkg::*;

  logic        i_mdu_valid;
  funct3_t     i_mdu_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_mdu_ready;
  logic [31:0] o_rd;

  modport master (
    output i_mdu_valid,
    output i_mdu_op,
    output i_rs1,
    output i_rs2,
    input  o_mdu_ready,
    input  o_rd
  );

  modport slave (
    input  i_mdu_valid,
    input  i_mdu_op,
    input  i_rs1,
    input  i_rs2,
    output o_mdu_ready,
    output o_rd
  );

endinterface

// File: rtl/serv_mdu_sign.sv
// Operand magnitude and result sign fix-up for the MDU.
// Purely combinational; the iteration core sees unsigned values.
module serv_mdu_sign
  import serv_mdu_pkg::*;
(
  input  funct3_t     i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_mag_a,
  output logic [31:0] o_mag_b,
  output logic        o_neg,
  input  funct3_t     i_res_op,
  input  logic        i_res_neg,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_res
);

  logic sa;
  logic sb;
  logic na;
  logic nb;

  logic [63:0] full;
  logic [31:0] dval;

  // Which operands are signed and what sign the result takes.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (i_op)
      OP_MULH:   begin sa = 1'b1; sb = 1'b1; end
      OP_MULHSU: begin sa = 1'b1; end
      OP_DIV:    begin sa = 1'b1; sb = 1'b1; end
      OP_REM:    begin sa = 1'b1; sb = 1'b1; end
      default:   begin sa = 1'b0; sb = 1'b0; end
    endcase
    na = sa & i_rs1[31];
    nb = sb & i_rs2[31];
    o_mag_a = na ? (~i_rs1 + 32'd1) : i_rs1;
    o_mag_b = nb ? (~i_rs2 + 32'd1) : i_rs2;
    if (op_is_rem(i_op)) begin
      o_neg = na;
    end else if (op_is_div(i_op)) begin
      // x/0 must stay all-ones, so never negate it
      o_neg = (na ^ nb) & (i_rs2 != 32'd0);
    end else begin
      o_neg = na ^ nb;
    end
  end

  // Negate the unsigned result and pick the wanted half.
  always_comb begin
    full = {i_hi, i_lo};
    if (i_res_neg) begin
      full = ~full + 64'd1;
    end
    dval = i_res_op[1] ? i_hi : i_lo;
    if (i_res_neg) begin
      dval = ~dval + 32'd1;
    end
    if (op_is_div(i_res_op)) begin
      o_res = dval;
    end else if (i_res_op == OP_MUL) begin
      o_res = full[31:0];
    end else begin
      o_res = full[63:32];
    end
  end

endmodule

// File: rtl/serv_mdu_resp.sv
// Serial radix-2 multiply/divide unit with fixed latency.
// One shared 33-bit adder drives both shift-add and restoring divide.
module serv_mdu_resp
  import serv_mdu_pkg::*;
#(
  parameter RESET_STRATEGY = "MINI",
  parameter int ITER = ITER_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  serv_mdu_resp_if.slave bus
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  funct3_t       op_q, op_d;
  logic          neg_q, neg_d;
  logic [32:0]   acc_q, acc_d;
  logic [31:0]   qr_q, qr_d;
  logic [32:0]   b_q, b_d;
  logic [31:0]   rd_q, rd_d;

  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic          neg_in;
  logic [31:0]   res;

  logic          is_div;
  logic [32:0]   r_sh;
  logic [32:0]   add_a;
  logic [32:0]   add_b;
  logic          add_c;
  logic [33:0]   sum;

  serv_mdu_sign u_sign (
    .i_op      (bus.i_mdu_op),
    .i_rs1     (bus.i_rs1),
    .i_rs2     (bus.i_rs2),
    .o_mag_a   (mag_a),
    .o_mag_b   (mag_b),
    .o_neg     (neg_in),
    .i_res_op  (op_q),
    .i_res_neg (neg_q),
    .i_hi      (acc_q[31:0]),
    .i_lo      (qr_q),
    .o_res     (res)
  );

  // Shared adder: acc + multiplicand, or shifted rem - divisor.
  always_comb begin
    is_div = op_is_div(op_q);
    r_sh   = {acc_q[31:0], qr_q[31]};
    add_a  = is_div ? r_sh : acc_q;
    add_b  = is_div ? ~b_q : (qr_q[0] ? b_q : 33'd0);
    add_c  = is_div;
    sum    = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_c};
  end

  // Next-state, counter and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    b_d     = b_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_mdu_valid) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          op_d    = bus.i_mdu_op;
          neg_d   = neg_in;
          acc_d   = '0;
          if (op_is_div(bus.i_mdu_op)) begin
            qr_d = mag_a;
            b_d  = {1'b0, mag_b};
          end else begin
            qr_d = mag_b;
            b_d  = {1'b0, mag_a};
          end
        end
      end
      S_BUSY: begin
        // after ITER steps the counter idles one settle cycle
        if (cnt_q == ITER_C) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div) begin
            acc_d = sum[33] ? sum[32:0] : r_sh;
            qr_d  = {qr_q[30:0], sum[33]};
          end else begin
            acc_d = {1'b0, sum[32:1]};
            qr_d  = {sum[0], qr_q[31:1]};
          end
        end
      end
      S_FIX: begin
        rd_d    = res;
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.i_mdu_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state always resets.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  generate
    if (RESET_STRATEGY != "NONE") begin : g_dp_rst
      // Datapath registers with reset.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          op_q  <= OP_MUL;
          neg_q <= 1'b0;
          acc_q <= '0;
          qr_q  <= '0;
          b_q   <= '0;
          rd_q  <= '0;
        end else begin
          op_q  <= op_d;
          neg_q <= neg_d;
          acc_q <= acc_d;
          qr_q  <= qr_d;
          b_q   <= b_d;
          rd_q  <= rd_d;
        end
      end
    end else begin : g_dp_norst
      // Datapath registers without reset.
      always_ff @(posedge i_clk) begin
        op_q  <= op_d;
        neg_q <= neg_d;
        acc_q <= acc_d;
        qr_q  <= qr_d;
        b_q   <= b_d;
        rd_q  <= rd_d;
      end
    end
  endgenerate

  assign bus.o_mdu_ready = ready_q;
  assign bus.o_rd        = rd_q;

endmodule

// File: tb/tb_serv_mdu_resp.sv
// Scoreboard bench for serv_mdu_resp.
// Expected results come from a 64-bit reference model.
module tb_serv_mdu_resp;

  logic clk;
  logic rst;

  serv_mdu_resp_if bus ();

  serv_mdu_resp dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint pa;
    longint pb;
    logic [63:0] p;
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      3'd1: begin
        pa = longint'(sa);
        pb = longint'(sb);
        p = pa * pb;
        return p[63:32];
      end
      3'd2: begin
        pa = longint'(sa);
        pb = longint'({32'd0, b});
        p = pa * pb;
        return p[63:32];
      end
      3'd3: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // hold: cycles valid stays high after the strobe
  // drop_at: BUSY cycle at which valid drops and operands scramble
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        input int drop_at);
    int lat;
    logic [31:0] e;
    logic [31:0] r;
    @(negedge clk);
    bus.i_mdu_valid = 1'b1;
    bus.i_mdu_op = op;
    bus.i_rs1 = a;
    bus.i_rs2 = b;
    exp_q.push_back(ref_mdu(op, a, b));
    @(posedge clk);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (drop_at != 0 && lat == drop_at) begin
        bus.i_mdu_valid = 1'b0;
        bus.i_rs1 = $urandom;
        bus.i_rs2 = $urandom;
        bus.i_mdu_op = 3'($urandom_range(0, 7));
      end
      if (bus.o_mdu_ready) break;
    end
    e = exp_q.pop_front();
    if (!bus.o_mdu_ready) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      chk("rd", bus.o_rd, e);
      chk("latency", 32'(lat), 32'd34);
    end
    r = bus.o_rd;
    @(posedge clk);
    #1;
    chk("strobe_width", {31'd0, bus.o_mdu_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", {31'd0, bus.o_mdu_ready}, 32'd0);
      chk("hold_rd", bus.o_rd, r);
    end
    @(negedge clk);
    bus.i_mdu_valid = 1'b0;
  endtask

  int nrdy;
  logic [31:0] pool [0:7];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_mdu_valid = 1'b0;
    bus.i_mdu_op = 3'd0;
    bus.i_rs1 = 32'd0;
    bus.i_rs2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.o_mdu_ready}, 32'd0);
    chk("rst_rd", bus.o_rd, 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(3'd5, 32'd5, 32'd0, 0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0, 0);
    run_op(3'd4, 32'hFFFFFFFB, 32'd0, 0, 0);
    run_op(3'd6, 32'hFFFFFFFB, 32'd0, 0, 0);
    run_op(3'd2, 32'h80000000, 32'h80000000, 0, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 0, 0);
    run_op(3'd5, 32'h80000000, 32'd3, 0, 0);

    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 10, 0);
    run_op(3'd7, 32'd100, 32'd7, 0, 0);

    run_op(3'd4, 32'hFFFF0000, 32'd9, 0, 5);
    run_op(3'd1, 32'h7FFFFFFF, 32'h80000001, 0, 20);

    // reset in the 10th BUSY cycle aborts the op
    @(negedge clk);
    bus.i_mdu_valid = 1'b1;
    bus.i_mdu_op = 3'd4;
    bus.i_rs1 = 32'd1000;
    bus.i_rs2 = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.i_mdu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rd", bus.o_rd, 32'd0);
    nrdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_mdu_ready) nrdy++;
    end
    chk("abort_ready", 32'(nrdy), 32'd0);
    run_op(3'd4, 32'd1000, 32'd7, 0, 0);

    pool[0] = 32'h00000000;
    pool[1] = 32'h00000001;
    pool[2] = 32'hFFFFFFFF;
    pool[3] = 32'h80000000;
    pool[4] = 32'h7FFFFFFF;
    pool[5] = 32'h0000FFFF;
    pool[6] = 32'hDEADBEEF;
    pool[7] = 32'h00000003;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_mdu_resp.md
SERV_MDU_RESP -- requirements
Module: serv_mdu_resp

Interface
REQ-001 Parameter RESET_STRATEGY, default "MINI"; "NONE" removes reset from datapath registers only.
REQ-002 Parameter ITER, default 32; number of iteration cycles, fixed at 32 for RV32.
REQ-003 i_clk  in  1  single clock, all logic rising-edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_mdu_valid  in  1  request from core state unit; level, held high past o_mdu_ready.
REQ-006 i_mdu_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_rs1  in  32  operand A (multiplicand/dividend), stable while i_mdu_valid high.
REQ-008 i_rs2  in  32  operand B (multiplier/divisor), stable while i_mdu_valid high.
REQ-009 o_mdu_ready  out  1  one-cycle result strobe.
REQ-010 o_rd  out  32  result, held stable from o_mdu_ready until next accept.

Function
REQ-011 FSM states IDLE, BUSY, FIX, DONE, HOLD; registered outputs only.
REQ-012 IDLE: i_mdu_valid=1 -> capture op, operand magnitudes and result-sign flags; clear iteration counter; go BUSY.
REQ-013 BUSY: one radix-2 step per cycle (shift-add multiply or restoring divide); after ITER steps go FIX.
REQ-014 FIX: apply sign correction and select high/low half or quotient/remainder into o_rd; go DONE.
REQ-015 DONE: o_mdu_ready=1 for exactly this cycle; go HOLD.
REQ-016 HOLD: stay while i_mdu_valid=1; go IDLE when i_mdu_valid=0; no new accept from HOLD.
REQ-017 Latency fixed: valid sampled at edge k -> o_mdu_ready high in cycle after edge k+ITER+2 (34th cycle), independent of operands and op.
REQ-018 MUL returns low 32 bits of product; MULH/MULHSU/MULHU return high 32 bits of signed x signed, signed x unsigned, unsigned x unsigned 64-bit product.
REQ-019 DIV/REM truncate toward zero; remainder takes sign of dividend.
REQ-020 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> i_rs1 unchanged.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
REQ-022 Special cases obey REQ-017 latency; no early completion.
REQ-023 Magnitude of 0x80000000 handled as unsigned 2^31 (33-bit internal width where needed); no truncation error.
REQ-024 i_mdu_valid dropping during BUSY/FIX does not abort; result still strobed.
REQ-025 Operand changes after accept do not affect the result.

Reset
REQ-026 i_rst -> state IDLE, o_mdu_ready=0, iteration counter 0, any state including mid-BUSY.
REQ-027 RESET_STRATEGY!="NONE" -> o_rd=0 and datapath accumulators cleared on reset; "NONE" -> datapath undefined until first FIX.
REQ-028 First cycle after reset release with i_mdu_valid=1 -> accept per REQ-012.

Structure
REQ-029 Package serv_mdu_pkg holds funct3 encodings, FSM state enum, ITER default.
REQ-030 Single sub-module serv_mdu_sign: operand absolute-value and result negate/select logic, combinational.
REQ-031 Iteration datapath and FSM in serv_mdu_resp; one 33-bit adder/subtractor shared by multiply and divide.

Verification
REQ-032 MUL rs1=7, rs2=0xFFFFFFFD -> o_rd=0xFFFFFFEB; o_mdu_ready exactly 34 cycles after accept, one cycle wide.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; latency still 34 cycles.
REQ-036 i_mdu_valid held high 10 cycles after o_mdu_ready -> no second ready, o_rd stable; drop then reassert -> new op accepted.
REQ-037 i_rst pulsed in 10th BUSY cycle -> o_mdu_ready never asserts for that op; next valid completes in 34 cycles with correct result.
